// File: rtl/trig_seq_ctrl.sv
// ---------------------------------------------------------------------------
// trig_seq_ctrl
//
// Sequencer for the ALCT pattern-finder datapath (trigger_rl). It arbitrates
// test-pulse inject, external-trigger and hot-channel-mask reload requests,
// drives the datapath control strobes/levels, watches hv for a hit inside a
// search window and enforces a post-LCT deadtime.
//
// Parameters
//   WIN_W        width of win_cfg (LCT search window counter)
//   DEAD_W       width of dead_cfg (post-LCT trig_stop counter)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   inj_req      1-cycle test-pulse injection request
//   ext_req      1-cycle external-trigger request
//   mask_req     1-cycle HCmask reload request
//   mask_done    mask loader finished (level, sampled while in MASK)
//   hv           best-LCT valid from trigger_rl
//   win_cfg      search window length minus 1
//   dead_cfg     deadtime in cycles, 0 = none (sampled on DEAD entry)
//   inject       1-cycle inject strobe
//   ext_trig_en  1-cycle external-trigger enable
//   input_disr   input disable, high while reloading the mask
//   trig_stop    pipeline freeze, high during deadtime
//   mask_ack     1-cycle mask reload complete
//   lct_seen     1-cycle hv accepted (IDLE or WAIT)
//   timeout      1-cycle window expired without hv
//   req_ovf      sticky, a request was dropped; cleared only by rst
//   busy         sequencer not idle
//   lct_cnt      (TRIG_SEQ_LCT_CNT_EN only) saturating count of lct_seen pulses
//   to_cnt       (TRIG_SEQ_LCT_CNT_EN only) saturating count of timeout pulses
//
// Build option
//   TRIG_SEQ_LCT_CNT_EN  adds the lct_cnt / to_cnt statistics counters.
// ---------------------------------------------------------------------------
module trig_seq_ctrl #(
  parameter int unsigned WIN_W  = 5,
  parameter int unsigned DEAD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inj_req,
  input  logic              ext_req,
  input  logic              mask_req,
  input  logic              mask_done,
  input  logic              hv,
  input  logic [WIN_W-1:0]  win_cfg,
  input  logic [DEAD_W-1:0] dead_cfg,
  output logic              inject,
  output logic              ext_trig_en,
  output logic              input_disr,
  output logic              trig_stop,
  output logic              mask_ack,
  output logic              lct_seen,
  output logic              timeout,
  output logic              req_ovf,
  output logic              busy
`ifdef TRIG_SEQ_LCT_CNT_EN
  ,
  output logic [15:0]       lct_cnt,
  output logic [15:0]       to_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StInj,
    StExt,
    StWait,
    StDead,
    StMask
  } state_e;

  state_e              state_q;
  logic [WIN_W-1:0]    win_cnt_q;
  logic [DEAD_W-1:0]   dead_cnt_q;

  // One pending flag per request type.
  logic                mask_pend_q, ext_pend_q, inj_pend_q;
  logic                mask_pend_d, ext_pend_d, inj_pend_d;

  logic                mask_any, ext_any, inj_any;
  logic                idle_arb;
  logic                gnt_mask, gnt_ext, gnt_inj;
  logic                ovf_hit;
  logic                dead_en;

  // Arbitration sees this cycle's pulse as well as the pending flag, so an
  // idle sequencer answers a request on the very next edge.
  always_comb begin
    mask_any    = mask_req | mask_pend_q;
    ext_any     = ext_req  | ext_pend_q;
    inj_any     = inj_req  | inj_pend_q;

    // A free-running LCT in IDLE wins over any grant; requests stay pending.
    idle_arb    = (state_q == StIdle) && !hv;

    gnt_mask    = idle_arb && mask_any;
    gnt_ext     = idle_arb && !mask_any && ext_any;
    gnt_inj     = idle_arb && !mask_any && !ext_any && inj_any;

    mask_pend_d = !gnt_mask && (mask_pend_q || mask_req);
    ext_pend_d  = !gnt_ext  && (ext_pend_q  || ext_req);
    inj_pend_d  = !gnt_inj  && (inj_pend_q  || inj_req);

    // A second pulse while its flag is still set is lost.
    ovf_hit     = (mask_req && mask_pend_q) ||
                  (ext_req  && ext_pend_q)  ||
                  (inj_req  && inj_pend_q);

    dead_en     = (dead_cfg != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      win_cnt_q   <= '0;
      dead_cnt_q  <= '0;
      mask_pend_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      inj_pend_q  <= 1'b0;
      inject      <= 1'b0;
      ext_trig_en <= 1'b0;
      input_disr  <= 1'b0;
      trig_stop   <= 1'b0;
      mask_ack    <= 1'b0;
      lct_seen    <= 1'b0;
      timeout     <= 1'b0;
      req_ovf     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      inject      <= 1'b0;
      ext_trig_en <= 1'b0;
      mask_ack    <= 1'b0;
      lct_seen    <= 1'b0;
      timeout     <= 1'b0;

      mask_pend_q <= mask_pend_d;
      ext_pend_q  <= ext_pend_d;
      inj_pend_q  <= inj_pend_d;
      req_ovf     <= req_ovf | ovf_hit;

      unique case (state_q)
        StIdle: begin
          if (hv) begin
            lct_seen <= 1'b1;
            if (dead_en) begin
              state_q    <= StDead;
              trig_stop  <= 1'b1;
              dead_cnt_q <= dead_cfg - DEAD_W'(1);
              busy       <= 1'b1;
            end
          end else if (gnt_mask) begin
            state_q    <= StMask;
            input_disr <= 1'b1;
            busy       <= 1'b1;
          end else if (gnt_ext) begin
            state_q     <= StExt;
            ext_trig_en <= 1'b1;
            busy        <= 1'b1;
          end else if (gnt_inj) begin
            state_q <= StInj;
            inject  <= 1'b1;
            busy    <= 1'b1;
          end
        end

        // The strobe was raised on entry; these states just open the window.
        StInj, StExt: begin
          win_cnt_q <= win_cfg;
          state_q   <= StWait;
        end

        StWait: begin
          // hv is checked before the counter so a hit in the final window
          // cycle is reported as a hit rather than a timeout.
          if (hv) begin
            lct_seen <= 1'b1;
            if (dead_en) begin
              state_q    <= StDead;
              trig_stop  <= 1'b1;
              dead_cnt_q <= dead_cfg - DEAD_W'(1);
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else if (win_cnt_q == '0) begin
            timeout <= 1'b1;
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            win_cnt_q <= win_cnt_q - WIN_W'(1);
          end
        end

        // dead_cnt_q was loaded with dead_cfg-1 on entry, giving exactly
        // dead_cfg cycles of trig_stop. hv is ignored here.
        StDead: begin
          if (dead_cnt_q == '0) begin
            state_q   <= StIdle;
            trig_stop <= 1'b0;
            busy      <= 1'b0;
          end else begin
            dead_cnt_q <= dead_cnt_q - DEAD_W'(1);
          end
        end

        // Holds indefinitely until the loader reports completion.
        StMask: begin
          if (mask_done) begin
            mask_ack   <= 1'b1;
            input_disr <= 1'b0;
            state_q    <= StIdle;
            busy       <= 1'b0;
          end
        end

        default: begin
          state_q    <= StIdle;
          trig_stop  <= 1'b0;
          input_disr <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRIG_SEQ_LCT_CNT_EN
  // Statistics counters, counted from the registered pulses; saturate at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      lct_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (lct_seen && (lct_cnt != 16'hFFFF)) begin
        lct_cnt <= lct_cnt + 16'd1;
      end
      if (timeout && (to_cnt != 16'hFFFF)) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Scoreboard bench for trig_seq_ctrl. Cycle k is the interval following the
// k-th rising clock edge; inputs are driven 1 ns after an edge and outputs
// are sampled on the falling edge.
module tb_trig_seq_ctrl;

  localparam int unsigned WIN_W  = 5;
  localparam int unsigned DEAD_W = 4;

  localparam logic [4:0] SInj = 5'b10000;
  localparam logic [4:0] SExt = 5'b01000;
  localparam logic [4:0] SAck = 5'b00100;
  localparam logic [4:0] SLct = 5'b00010;
  localparam logic [4:0] STo  = 5'b00001;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              inj_req = 1'b0, ext_req = 1'b0, mask_req = 1'b0;
  logic              mask_done = 1'b0, hv = 1'b0;
  logic [WIN_W-1:0]  win_cfg = 5'd4;
  logic [DEAD_W-1:0] dead_cfg = 4'd3;
  logic              inject, ext_trig_en, input_disr, trig_stop;
  logic              mask_ack, lct_seen, timeout, req_ovf, busy;
`ifdef TRIG_SEQ_LCT_CNT_EN
  logic [15:0]       lct_cnt, to_cnt;
`endif

  trig_seq_ctrl #(
    .WIN_W (WIN_W),
    .DEAD_W(DEAD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inj_req    (inj_req),
    .ext_req    (ext_req),
    .mask_req   (mask_req),
    .mask_done  (mask_done),
    .hv         (hv),
    .win_cfg    (win_cfg),
    .dead_cfg   (dead_cfg),
    .inject     (inject),
    .ext_trig_en(ext_trig_en),
    .input_disr (input_disr),
    .trig_stop  (trig_stop),
    .mask_ack   (mask_ack),
    .lct_seen   (lct_seen),
    .timeout    (timeout),
    .req_ovf    (req_ovf),
    .busy       (busy)
`ifdef TRIG_SEQ_LCT_CNT_EN
    ,
    .lct_cnt    (lct_cnt),
    .to_cnt     (to_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] stb;
  } ev_t;

  typedef struct {
    int          cyc;
    logic        ts, dis, bsy, ovf, chk_cnt;
    logic [15:0] lct, tc;
  } lv_t;

  ev_t evq[$];
  lv_t lvq[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic exp_ev(input int c, input logic [4:0] s);
    ev_t e;
    e.cyc = c;
    e.stb = s;
    evq.push_back(e);
  endtask

  task automatic exp_lv(input int c, input logic ts, input logic dis, input logic bsy,
                        input logic ovf);
    lv_t e;
    e.cyc = c; e.ts = ts; e.dis = dis; e.bsy = bsy; e.ovf = ovf;
    e.chk_cnt = 1'b0; e.lct = '0; e.tc = '0;
    lvq.push_back(e);
  endtask

  task automatic exp_cnt(input int c, input logic ts, input logic dis, input logic bsy,
                         input logic ovf, input logic [15:0] l, input logic [15:0] t);
    lv_t e;
    e.cyc = c; e.ts = ts; e.dis = dis; e.bsy = bsy; e.ovf = ovf;
    e.chk_cnt = 1'b1; e.lct = l; e.tc = t;
    lvq.push_back(e);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops an expected event whenever any strobe is presented, and
  // checks queued level snapshots at their cycle.
  always @(negedge clk) begin
    logic [4:0] stb;
    stb = {inject, ext_trig_en, mask_ack, lct_seen, timeout};
    while (lvq.size() > 0 && lvq[0].cyc < cyc) begin
      lv_t e;
      e = lvq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL level_missed: snapshot for cyc %0d never sampled (now %0d)", e.cyc, cyc);
    end
    if (lvq.size() > 0 && lvq[0].cyc == cyc) begin
      lv_t e;
      e = lvq.pop_front();
      n_vec++;
      if ({trig_stop, input_disr, busy, req_ovf} !== {e.ts, e.dis, e.bsy, e.ovf}) begin
        n_bad++;
        $display("FAIL levels@%0d: got ts/dis/busy/ovf=%b%b%b%b want %b%b%b%b", cyc,
                 trig_stop, input_disr, busy, req_ovf, e.ts, e.dis, e.bsy, e.ovf);
      end
`ifdef TRIG_SEQ_LCT_CNT_EN
      if (e.chk_cnt) begin
        n_vec++;
        if (lct_cnt !== e.lct || to_cnt !== e.tc) begin
          n_bad++;
          $display("FAIL counters@%0d: got lct=%h to=%h want lct=%h to=%h", cyc,
                   lct_cnt, to_cnt, e.lct, e.tc);
        end
      end
`endif
    end
    if (|stb) begin
      n_vec++;
      if (evq.size() == 0) begin
        n_bad++;
        $display("FAIL event_unexpected: got stb=%b at cyc %0d, want none", stb, cyc);
      end else begin
        ev_t e;
        e = evq.pop_front();
        if (stb !== e.stb || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL event: got stb=%b at cyc %0d, want stb=%b at cyc %0d", stb, cyc,
                   e.stb, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset held through cycles 0..2.
    exp_lv(3, 0, 0, 0, 0);
    to_cyc(3);
    rst = 1'b0;

    // Inject, hit inside the window, 3-cycle deadtime.
    exp_ev(11, SInj); exp_lv(11, 0, 0, 1, 0); exp_lv(14, 0, 0, 1, 0);
    exp_ev(15, SLct); exp_lv(15, 1, 0, 1, 0); exp_lv(17, 1, 0, 1, 0);
    exp_lv(18, 0, 0, 0, 0);
    to_cyc(10); inj_req = 1'b1;
    to_cyc(11); inj_req = 1'b0;
    to_cyc(14); hv = 1'b1;
    to_cyc(15); hv = 1'b0;

    // External trigger, window of 3, no hit.
    exp_ev(21, SExt); exp_lv(23, 0, 0, 1, 0); exp_ev(25, STo);
    exp_lv(25, 0, 0, 0, 0); exp_lv(26, 0, 0, 0, 0);
    to_cyc(20); win_cfg = 5'd2; ext_req = 1'b1;
    to_cyc(21); ext_req = 1'b0;

    // Simultaneous requests: mask, then ext, then inj.
    exp_lv(31, 0, 1, 1, 0); exp_lv(33, 0, 1, 1, 0); exp_lv(35, 0, 1, 1, 0);
    exp_ev(36, SAck); exp_lv(36, 0, 0, 0, 0); exp_ev(37, SExt); exp_ev(41, STo);
    exp_ev(42, SInj); exp_ev(46, STo); exp_lv(47, 0, 0, 0, 0);
    to_cyc(30); mask_req = 1'b1; ext_req = 1'b1; inj_req = 1'b1;
    to_cyc(31); mask_req = 1'b0; ext_req = 1'b0; inj_req = 1'b0;
    to_cyc(35); mask_done = 1'b1;
    to_cyc(36); mask_done = 1'b0;

    // hv in the last window cycle is a hit; dead_cfg=0 returns straight to IDLE.
    exp_ev(51, SInj); exp_ev(55, SLct); exp_lv(55, 0, 0, 0, 0); exp_lv(56, 0, 0, 0, 0);
    to_cyc(50); dead_cfg = 4'd0; inj_req = 1'b1;
    to_cyc(51); inj_req = 1'b0;
    to_cyc(54); hv = 1'b1;
    to_cyc(55); hv = 1'b0;

    // Free-running LCT into DEAD, two inj_req during DEAD -> overflow, one inject.
    exp_ev(61, SLct); exp_lv(62, 1, 0, 1, 0); exp_lv(63, 1, 0, 1, 1);
    exp_lv(64, 0, 0, 0, 1); exp_ev(65, SInj); exp_ev(69, STo); exp_lv(70, 0, 0, 0, 1);
    to_cyc(60); dead_cfg = 4'd3; hv = 1'b1;
    to_cyc(61); hv = 1'b0; inj_req = 1'b1;
    to_cyc(62); inj_req = 1'b1;
    to_cyc(63); inj_req = 1'b0;

    // hv every cycle with dead_cfg=0; a request meanwhile waits for hv to drop.
    for (int i = 76; i <= 85; i++) exp_ev(i, SLct);
    exp_lv(80, 0, 0, 0, 1); exp_ev(86, SInj); exp_ev(90, STo);
    exp_cnt(92, 0, 0, 0, 1, 16'd13, 16'd5);
    to_cyc(75); dead_cfg = 4'd0; hv = 1'b1;
    to_cyc(80); inj_req = 1'b1;
    to_cyc(81); inj_req = 1'b0;
    to_cyc(85); hv = 1'b0;

    // Reset mid-WAIT with a request pending: everything clears, nothing follows.
    exp_ev(96, SInj); exp_lv(97, 0, 0, 1, 1); exp_cnt(99, 0, 0, 0, 0, 16'd0, 16'd0);
    exp_lv(101, 0, 0, 0, 0); exp_lv(112, 0, 0, 0, 0);
    to_cyc(95); win_cfg = 5'd10; dead_cfg = 4'd3; inj_req = 1'b1;
    to_cyc(96); inj_req = 1'b0;
    to_cyc(97); inj_req = 1'b1;
    to_cyc(98); inj_req = 1'b0; rst = 1'b1;
    to_cyc(101); rst = 1'b0;

`ifdef TRIG_SEQ_LCT_CNT_EN
    // Long free-running LCT burst: lct_cnt saturates at 16'hFFFF.
    for (int i = 116; i <= 115 + 65540; i++) exp_ev(i, SLct);
    exp_cnt(115 + 65548, 0, 0, 0, 0, 16'hFFFF, 16'd0);
    to_cyc(115); dead_cfg = 4'd0; hv = 1'b1;
    to_cyc(115 + 65540); hv = 1'b0;
    to_cyc(115 + 65550);
`else
    to_cyc(115);
`endif

    while (evq.size() > 0) begin
      ev_t e;
      e = evq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL event_missing: got none, want stb=%b at cyc %0d", e.stb, e.cyc);
    end
    while (lvq.size() > 0) begin
      lv_t e;
      e = lvq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL level_missing: got none, want snapshot at cyc %0d", e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
